// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Hyperbus Wishbone front end: one-hot state
// encodings and the default downstream response timeout.
package hyperbus_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_READ  = 6'b000010,
        ST_WRITE = 6'b000100,
        ST_ACK   = 6'b001000,
        ST_ERR   = 6'b010000,
        ST_DRAIN = 6'b100000
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1023;

endpackage

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone slave that turns single reads/writes into request pulses for hyperbus_fifo.
// Optional response timeout is enabled with macro HYPERBUS_WB_TIMEOUT_EN.
module hyperbus_wb_bridge
    import hyperbus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    rrq,
    output logic                    wrq,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   tx_dat_o,
    output logic [DATA_WIDTH/8-1:0] tx_mask_o,
    input  logic                    tx_done,
    input  logic [DATA_WIDTH-1:0]   rx_dat_i,
    input  logic                    rx_valid
);

    localparam int SEL_W = DATA_WIDTH / 8;

    state_t                  state_reg, state_next;
    logic                    rrq_reg, rrq_next;
    logic                    wrq_reg, wrq_next;
    logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
    logic [DATA_WIDTH-1:0]   tx_dat_reg, tx_dat_next;
    logic [SEL_W-1:0]        tx_mask_reg, tx_mask_next;
    logic [DATA_WIDTH-1:0]   rd_dat_reg, rd_dat_next;
    logic                    pend_we_reg, pend_we_next;
    logic                    drain_err_reg, drain_err_next;
    logic                    wb_req;
    logic                    pend_done;

`ifdef HYPERBUS_WB_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             timeout;

    // Saturating increment; the state leaves READ/WRITE as soon as it hits the limit.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign timeout = (cnt_inc == CNT_MAX);
    assign wb_err_o = (state_reg == ST_ERR) | drain_err_reg;
`else
    assign wb_err_o = drain_err_reg;
`endif

    assign wb_req    = wb_cyc_i & wb_stb_i;
    assign pend_done = pend_we_reg ? tx_done : rx_valid;
    assign wb_ack_o  = (state_reg == ST_ACK);
    assign wb_dat_o  = rd_dat_reg;
    assign rrq       = rrq_reg;
    assign wrq       = wrq_reg;
    assign adr_o     = adr_reg;
    assign tx_dat_o  = tx_dat_reg;
    assign tx_mask_o = tx_mask_reg;

    always_comb begin
        state_next     = state_reg;
        rrq_next       = 1'b0;
        wrq_next       = 1'b0;
        adr_next       = adr_reg;
        tx_dat_next    = tx_dat_reg;
        tx_mask_next   = tx_mask_reg;
        rd_dat_next    = rd_dat_reg;
        pend_we_next   = pend_we_reg;
        drain_err_next = 1'b0;
`ifdef HYPERBUS_WB_TIMEOUT_EN
        cnt_next       = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // A strobe seen while err is showing belongs to the refused access.
                if (wb_req && !wb_err_o) begin
                    adr_next     = wb_adr_i >> 1;
                    pend_we_next = wb_we_i;
`ifdef HYPERBUS_WB_TIMEOUT_EN
                    cnt_next     = '0;
`endif
                    if (wb_we_i) begin
                        wrq_next     = 1'b1;
                        tx_dat_next  = wb_dat_i;
                        tx_mask_next = ~wb_sel_i;
                        state_next   = ST_WRITE;
                    end else begin
                        rrq_next   = 1'b1;
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
`ifdef HYPERBUS_WB_TIMEOUT_EN
                cnt_next = cnt_inc;
`endif
                if (!wb_cyc_i) begin
                    state_next = rx_valid ? ST_IDLE : ST_DRAIN;
                end else if (rx_valid) begin
                    rd_dat_next = rx_dat_i;
                    state_next  = ST_ACK;
                end
`ifdef HYPERBUS_WB_TIMEOUT_EN
                else if (timeout) begin
                    state_next = ST_ERR;
                end
`endif
            end
            ST_WRITE: begin
`ifdef HYPERBUS_WB_TIMEOUT_EN
                cnt_next = cnt_inc;
`endif
                if (!wb_cyc_i) begin
                    state_next = tx_done ? ST_IDLE : ST_DRAIN;
                end else if (tx_done) begin
                    state_next = ST_ACK;
                end
`ifdef HYPERBUS_WB_TIMEOUT_EN
                else if (timeout) begin
                    state_next = ST_ERR;
                end
`endif
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
`ifdef HYPERBUS_WB_TIMEOUT_EN
            ST_ERR: begin
                // The late response may still land during the err cycle itself.
                state_next = pend_done ? ST_IDLE : ST_DRAIN;
            end
`endif
            ST_DRAIN: begin
                if (pend_done) begin
                    state_next = ST_IDLE;
                end
                if (wb_req && !drain_err_reg) begin
                    drain_err_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rrq_reg       <= 1'b0;
            wrq_reg       <= 1'b0;
            adr_reg       <= '0;
            tx_dat_reg    <= '0;
            tx_mask_reg   <= '0;
            rd_dat_reg    <= '0;
            pend_we_reg   <= 1'b0;
            drain_err_reg <= 1'b0;
`ifdef HYPERBUS_WB_TIMEOUT_EN
            cnt_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            rrq_reg       <= rrq_next;
            wrq_reg       <= wrq_next;
            adr_reg       <= adr_next;
            tx_dat_reg    <= tx_dat_next;
            tx_mask_reg   <= tx_mask_next;
            rd_dat_reg    <= rd_dat_next;
            pend_we_reg   <= pend_we_next;
            drain_err_reg <= drain_err_next;
`ifdef HYPERBUS_WB_TIMEOUT_EN
            cnt_reg       <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Self-checking bench for hyperbus_wb_bridge: directed and randomized Wishbone
// transactions against expectations derived from the bus-level behaviour.
module tb_hyperbus_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        rrq;
    logic        wrq;
    logic [31:0] adr_o;
    logic [31:0] tx_dat_o;
    logic [3:0]  tx_mask_o;
    logic        tx_done = 1'b0;
    logic [31:0] rx_dat_i = '0;
    logic        rx_valid = 1'b0;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int req_mon = 0;
    int exp_reqs = 0;
    logic [31:0] model_dat = '0;

    hyperbus_wb_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .rrq(rrq), .wrq(wrq), .adr_o(adr_o), .tx_dat_o(tx_dat_o),
        .tx_mask_o(tx_mask_o), .tx_done(tx_done), .rx_dat_i(rx_dat_i),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    // Every high cycle of rrq/wrq counts, so a stretched pulse shows up as extra requests.
    always @(posedge clk) begin
        if (rrq | wrq) req_mon <= req_mon + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access with the downstream response 'delay' cycles after the request pulse.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay, input bit hold);
        logic [31:0] rdat;
        logic [31:0] exp_adr;
        logic [3:0]  exp_mask;
        rdat     = $urandom;
        exp_adr  = adr / 2;
        exp_mask = 4'hF ^ sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        tick();
        exp_reqs++;
        check(we ? "wrq_pulse" : "rrq_pulse", {rrq, wrq}, we ? 2'b01 : 2'b10);
        check("adr_o", adr_o, exp_adr);
        if (we) begin
            check("tx_dat_o", tx_dat_o, dat);
            check("tx_mask_o", tx_mask_o, exp_mask);
        end
        for (int i = 0; i < delay; i++) begin
            // The response type that does not belong to this access must be ignored.
            if (we) begin
                rx_valid = 1'($urandom_range(0, 1));
                rx_dat_i = $urandom;
            end else begin
                tx_done = 1'($urandom_range(0, 1));
            end
            tick();
            check("wait_quiet", {wb_ack_o, wb_err_o, rrq, wrq}, 4'b0000);
        end
        rx_valid = 1'b0; tx_done = 1'b0;
        if (we) begin
            tx_done = 1'b1;
        end else begin
            rx_valid = 1'b1;
            rx_dat_i = rdat;
            model_dat = rdat;
        end
        tick();
        tx_done = 1'b0; rx_valid = 1'b0;
        check("ack", {wb_ack_o, wb_err_o}, 2'b10);
        check("wb_dat_o_ack", wb_dat_o, model_dat);
        $display("xfer we=%0d adr=%08h dat=%08h sel=%01h delay=%0d rd=%08h", we, adr, dat, sel, delay, wb_dat_o);
        if (!hold) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            tick();
            check("ack_one_cycle", wb_ack_o, 1'b0);
            check("wb_dat_o_hold", wb_dat_o, model_dat);
        end
    endtask

    initial begin
        int n;
        logic seen;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ctrl", {rrq, wrq, wb_ack_o, wb_err_o}, 4'b0000);
        check("reset_data", {adr_o, tx_dat_o}, 64'h0);
        check("reset_mask_rd", {tx_mask_o, wb_dat_o}, 36'h0);

        // Directed write and read.
        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 5, 1'b0);
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3, 1'b0);
        check("req_count_dir", req_mon, exp_reqs);

        // Back-to-back with strobe held through the ACK cycle.
        xfer(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 2, 1'b1);
        wb_we_i = 1'b0; wb_adr_i = 32'h0000_0204;
        tick();
        check("b2b_no_req_after_ack", {rrq, wrq, wb_ack_o}, 3'b000);
        xfer(1'b0, 32'h0000_0204, 32'h0, 4'hF, 1, 1'b0);
        check("req_count_b2b", req_mon, exp_reqs);

        // Randomized traffic, including zero-latency responses.
        for (int t = 0; t < 24; t++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7), 1'b0);
        end
        check("req_count_rand", req_mon, exp_reqs);

        // Abort a write by dropping cyc; the bridge must drain the tx_done.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h40; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hF;
        tick();
        exp_reqs++;
        check("abort_wrq", wrq, 1'b1);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        check("abort_no_ack", {wb_ack_o, wb_err_o}, 2'b00);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        tick();
        check("drain_err", {wb_err_o, wb_ack_o, rrq, wrq}, 4'b1000);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        check("drain_err_pulse", wb_err_o, 1'b0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("drain_exit_no_ack", {wb_ack_o, wb_err_o}, 2'b00);
        $display("abort write drained");
        xfer(1'b0, 32'h0000_0066, 32'h0, 4'hF, 2, 1'b0);
        check("req_count_abort", req_mon, exp_reqs);

        // Reset in the middle of a read.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h88;
        tick();
        exp_reqs++;
        check("rst_rrq", rrq, 1'b1);
        tick();
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        rst = 1'b0;
        model_dat = '0;
        check("rst_mid_ctrl", {rrq, wrq, wb_ack_o, wb_err_o}, 4'b0000);
        check("rst_mid_data", {adr_o, wb_dat_o}, 64'h0);
        check("rst_mid_tx", {tx_dat_o, tx_mask_o}, 36'h0);
        rx_valid = 1'b1; rx_dat_i = 32'hA5A5_A5A5;
        tick();
        rx_valid = 1'b0;
        tick();
        check("rst_late_rx_ignored", {wb_ack_o, wb_err_o, rrq, wrq}, 4'b0000);
        check("rst_late_rx_dat", wb_dat_o, model_dat);
        $display("reset mid-read abandoned");

`ifdef HYPERBUS_WB_TIMEOUT_EN
        // Read with a very late response: err 16 cycles after rrq.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h300;
        tick();
        exp_reqs++;
        check("to_rrq", rrq, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!wb_err_o && n < 40) begin
            tick();
            n++;
            seen = seen | wb_ack_o;
        end
        check("timeout_cycle", n, 16);
        check("timeout_no_ack", {seen, wb_ack_o}, 2'b00);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        check("timeout_err_pulse", wb_err_o, 1'b0);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tick();
        check("timeout_drain_err", {wb_err_o, rrq, wrq}, 3'b100);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        rx_valid = 1'b1; rx_dat_i = 32'h5A5A_0000;
        tick();
        rx_valid = 1'b0;
        check("timeout_late_rx", {wb_ack_o, wb_err_o}, 2'b00);
        check("timeout_late_dat", wb_dat_o, model_dat);
        $display("timeout read: err after %0d cycles", n);
`else
        // Without the timeout the bridge waits indefinitely.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h300;
        tick();
        exp_reqs++;
        check("long_rrq", rrq, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | wb_err_o | wb_ack_o;
        end
        check("long_wait_quiet", seen, 1'b0);
        rx_valid = 1'b1; rx_dat_i = 32'h5A5A_0000; model_dat = 32'h5A5A_0000;
        tick();
        rx_valid = 1'b0;
        check("long_ack", {wb_ack_o, wb_err_o}, 2'b10);
        check("long_dat", wb_dat_o, model_dat);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        $display("long read acked after 40 cycles");
`endif
        xfer(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'b0101, 1, 1'b0);
        check("req_count_final", req_mon, exp_reqs);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hyperbus_wb_bridge.md
HYPERBUS_WB_BRIDGE -- requirements
Module: hyperbus_wb_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone and FIFO data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, Wishbone byte-address width and FIFO address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum wait for a downstream response.
REQ-004 Clocking: one clock; reset is synchronous and active-high. Ports clk (in, 1, clock) and rst (in, 1, reset).
REQ-005 SHALL have Wishbone slave ports:
- wb_adr_i  in  ADDR_WIDTH  byte address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  DATA_WIDTH/8  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  DATA_WIDTH  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
REQ-006 SHALL have FIFO-side ports:
- rrq  out  1  read request pulse
- wrq  out  1  write request pulse
- adr_o  out  ADDR_WIDTH  Hyperbus word address
- tx_dat_o  out  DATA_WIDTH  write data
- tx_mask_o  out  DATA_WIDTH/8  byte mask, 1 = masked
- tx_done  in  1  write-complete pulse
- rx_dat_i  in  DATA_WIDTH  read data
- rx_valid  in  1  read-data pulse

Function
REQ-007 States SHALL be IDLE, READ, WRITE, ACK, ERR and DRAIN, one-hot encoded.
REQ-008 In IDLE, when wb_cyc_i&wb_stb_i, the block SHALL pulse rrq (wb_we_i=0) or wrq (wb_we_i=1) for exactly one cycle and go to READ or WRITE.
REQ-009 On request, adr_o SHALL be wb_adr_i>>1 (16-bit word address), zero-filled MSB, held until the next request.
REQ-010 On write request, tx_dat_o SHALL be wb_dat_i and tx_mask_o SHALL be ~wb_sel_i, both registered in the same cycle as wrq.
REQ-011 In READ, on rx_valid the block SHALL register wb_dat_o<=rx_dat_i and go to ACK. tx_done is ignored in READ.
REQ-012 In WRITE, on tx_done the block SHALL go to ACK. rx_valid is ignored in WRITE.
REQ-013 ACK SHALL drive wb_ack_o=1 for exactly one cycle, then return to IDLE. A strobe still high in that cycle SHALL NOT start a request.
REQ-014 Minimum latency: request accepted at cycle N, rrq/wrq at N+1, response at N+1+k, wb_ack_o at N+2+k.
REQ-015 If wb_cyc_i drops while in READ/WRITE, the block SHALL go to DRAIN and SHALL NOT assert wb_ack_o.
REQ-016 DRAIN SHALL wait for the pending response type (rx_valid or tx_done), then go to IDLE.
REQ-017 While in DRAIN, any wb_cyc_i&wb_stb_i SHALL be answered by a one-cycle wb_err_o, with no rrq/wrq issued.
REQ-018 wb_ack_o and wb_err_o SHALL never be high in the same cycle.
REQ-019 wb_dat_o SHALL hold its last value outside ACK.

Reset
REQ-020 While rst is high at a clk edge: state=IDLE; rrq, wrq, wb_ack_o, wb_err_o=0; adr_o, tx_dat_o, tx_mask_o, wb_dat_o=0; timeout counter=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it without ack or err. Response pulses arriving after reset in IDLE SHALL be ignored.

Configuration
REQ-022 With macro HYPERBUS_WB_TIMEOUT_EN defined, a counter SHALL clear on entry to READ/WRITE and increment each cycle there.
REQ-023 With HYPERBUS_WB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL go to ERR, pulse wb_err_o one cycle, then go to DRAIN.
REQ-024 With HYPERBUS_WB_TIMEOUT_EN defined, the counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and SHALL NOT wrap.
REQ-025 Without HYPERBUS_WB_TIMEOUT_EN, no counter or ERR logic SHALL exist, and READ/WRITE SHALL wait indefinitely.

Structure
REQ-026 State encodings and the default TIMEOUT_CYCLES SHALL live in shared package hyperbus_pkg.
REQ-027 The block SHALL be a single module with no sub-modules, instantiated upstream of hyperbus_fifo on its user clock.

Verification
REQ-028 Write test: wb write adr=0x0000_0010, dat=0xDEADBEEF, sel=4'b0011, tx_done 5 cycles after wrq -> one wrq pulse, adr_o=0x8, tx_dat_o=0xDEADBEEF, tx_mask_o=4'b1100, wb_ack_o one cycle after tx_done.
REQ-029 Read test: wb read adr=0x20, rx_valid with rx_dat_i=0x12345678 -> rrq once, adr_o=0x10, wb_dat_o=0x12345678 with wb_ack_o.
REQ-030 Back-to-back test: write then read with stb held continuously -> exactly two requests, no request issued during ACK cycles.
REQ-031 Timeout test (HYPERBUS_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with no rx_valid -> wb_err_o at cycle 16 after rrq. A new stb before the late rx_valid -> immediate wb_err_o. After rx_valid -> IDLE.
REQ-032 Abort/reset test: drop wb_cyc_i mid-write -> no ack, DRAIN until tx_done. Separately, rst in READ -> all outputs 0 next cycle, later rx_valid ignored.
